// File: rtl/copperv_lsu.sv
// Load/store unit for copperv: issues RV32/RV64 loads and stores on a pipelined
// Wishbone B4 master port with up to DEPTH transactions in flight, in-order responses.
module copperv_lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_store,
  input  logic [2:0]              req_funct,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic                    resp_misaligned,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  input  logic                    wb_stall_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = 1 + 3 + OW;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam bit WIDE = (DATA_WIDTH == 64);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  function automatic logic [DATA_WIDTH-1:0] low_mask(input logic [1:0] sz);
    int nbits;
    nbits = 32'd8 << sz;
    if (nbits >= DATA_WIDTH) low_mask = '1;
    else                     low_mask = ~({DATA_WIDTH{1'b1}} << nbits);
  endfunction

  function automatic logic [NB-1:0] sel_mask(input logic [1:0] sz, input logic [OW-1:0] off);
    logic [NB-1:0] m;
    int n;
    n = 32'd1 << sz;
    if (n >= NB) m = '1;
    else         m = ~({NB{1'b1}} << n);
    sel_mask = m << off;
  endfunction

  // Right-align the addressed bytes, then sign- or zero-extend from the access size.
  function automatic logic [DATA_WIDTH-1:0] load_ext(input logic [DATA_WIDTH-1:0] d,
                                                     input logic [2:0] funct,
                                                     input logic [OW-1:0] off);
    logic [DATA_WIDTH-1:0] s;
    logic [DATA_WIDTH-1:0] m;
    logic                  sign;
    s    = d >> {off, 3'b000};
    m    = low_mask(funct[1:0]);
    sign = |(s & (m ^ (m >> 1)));
    if (!funct[2] && sign) load_ext = s | ~m;
    else                   load_ext = s & m;
  endfunction

  state_t                r_state;
  logic                  r_cyc, r_stb, r_we;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [DATA_WIDTH-1:0] r_dat;
  logic [NB-1:0]         r_sel;
  logic [CW-1:0]         r_count;
  logic [TW-1:0]         r_tag_mem [DEPTH];
  logic [PW-1:0]         r_wptr, r_rptr;
  logic                  r_resp_valid, r_resp_err, r_resp_mis;
  logic [DATA_WIDTH-1:0] r_resp_rdata;

  logic [OW-1:0] w_offset, w_align_mask;
  logic [1:0]    w_size;
  logic          w_legal, w_misaligned, w_bad, w_slot, w_quiet;
  logic          w_acc, w_acc_ok, w_acc_bad, w_done, w_stb_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [TW-1:0] w_tag_head;

  // Request decode: legality per funct3 and width, natural alignment check.
  always_comb begin
    w_offset = req_addr[OW-1:0];
    w_size   = req_funct[1:0];
    w_legal  = 1'b0;
    case (req_funct)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b011:                 w_legal = WIDE;
      3'b100, 3'b101:         w_legal = !req_store;
      3'b110:                 w_legal = !req_store && WIDE;
      default:                w_legal = 1'b0;
    endcase
    w_align_mask = OW'((32'd1 << w_size) - 32'd1);
    w_misaligned = w_legal && ((w_offset & w_align_mask) != '0);
    w_bad        = !w_legal || w_misaligned;
  end

  // Bad requests wait for a fully drained bus so their error response stays in order.
  assign w_slot    = (!r_stb || !wb_stall_i) && (r_count < DEPTH_C);
  assign w_quiet   = (r_count == '0) && !r_stb;
  assign req_ready = rst && w_slot && (!w_bad || w_quiet);
  assign w_acc     = req_valid && req_ready;
  assign w_acc_ok  = w_acc && !w_bad;
  assign w_acc_bad = w_acc && w_bad;
  assign w_done    = (wb_ack_i || wb_err_i) && (r_count != '0);
  assign w_stb_nxt = w_acc_ok || (r_stb && wb_stall_i);

  // Outstanding count next value.
  always_comb begin
    case ({w_acc_ok, w_done})
      2'b10:   w_cnt_nxt = r_count + CW'(1);
      2'b01:   w_cnt_nxt = r_count - CW'(1);
      default: w_cnt_nxt = r_count;
    endcase
  end

  // Bus FSM and registered Wishbone request outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cyc   <= 1'b0;
      r_stb   <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_sel   <= '0;
      r_count <= '0;
    end else begin
      r_count <= w_cnt_nxt;
      if (w_acc_ok) begin
        r_stb <= 1'b1;
        r_we  <= req_store;
        r_adr <= {req_addr[ADDR_WIDTH-1:OW], {OW{1'b0}}};
        r_dat <= (req_wdata & low_mask(w_size)) << {w_offset, 3'b000};
        r_sel <= sel_mask(w_size, w_offset);
      end else if (!wb_stall_i) begin
        r_stb <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_acc_ok) begin
            r_state <= S_BUSY;
            r_cyc   <= 1'b1;
          end
        end
        S_BUSY: begin
          if (w_cnt_nxt == '0 && !w_stb_nxt) begin
            r_state <= S_IDLE;
            r_cyc   <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cyc   <= 1'b0;
        end
      endcase
    end
  end

  // Tag FIFO: occupancy always equals r_count, so pops never underflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_tag_mem[i] <= '0;
    end else begin
      if (w_acc_ok) begin
        r_tag_mem[r_wptr] <= {req_store, req_funct, w_offset};
        r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + PW'(1);
      end
      if (w_done) r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + PW'(1);
    end
  end

  assign w_tag_head = r_tag_mem[r_rptr];

  // Response register: bus completions, or immediate errors for rejected accesses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_mis   <= 1'b0;
      r_resp_rdata <= '0;
    end else if (w_done) begin
      r_resp_valid <= 1'b1;
      r_resp_mis   <= 1'b0;
      if (wb_err_i) begin
        r_resp_err   <= 1'b1;
        r_resp_rdata <= '0;
      end else begin
        r_resp_err   <= 1'b0;
        r_resp_rdata <= w_tag_head[TW-1] ? '0
                        : load_ext(wb_dat_i, w_tag_head[OW+2:OW], w_tag_head[OW-1:0]);
      end
    end else if (w_acc_bad) begin
      r_resp_valid <= 1'b1;
      r_resp_err   <= 1'b1;
      r_resp_mis   <= w_misaligned;
      r_resp_rdata <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_mis   <= 1'b0;
      r_resp_rdata <= '0;
    end
  end

  assign wb_cyc_o        = r_cyc;
  assign wb_stb_o        = r_stb;
  assign wb_we_o         = r_we;
  assign wb_adr_o        = r_adr;
  assign wb_dat_o        = r_dat;
  assign wb_sel_o        = r_sel;
  assign resp_valid      = r_resp_valid;
  assign resp_err        = r_resp_err;
  assign resp_misaligned = r_resp_mis;
  assign resp_rdata      = r_resp_rdata;

endmodule

// File: tb/tb_copperv_lsu.sv
// Scoreboard bench for copperv_lsu (32-bit, DEPTH=4) with a pipelined Wishbone
// slave model offering programmable stall, ack latency and error injection.
module tb_copperv_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_store = 1'b0;
  logic [2:0]  req_funct = 3'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        req_ready, resp_valid, resp_err, resp_misaligned;
  logic [31:0] resp_rdata;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stall_i = 1'b0, wb_ack_i = 1'b0, wb_err_i = 1'b0;
  logic [31:0] wb_dat_i = 32'd0;

  copperv_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct(req_funct), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .resp_misaligned(resp_misaligned),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_stall_i(wb_stall_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_dat_i(wb_dat_i)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [31:0] dat; logic err; } pend_t;
  typedef struct { logic we; logic [31:0] adr; logic [3:0] sel; logic [31:0] dat; } bus_t;

  pend_t       pend_q[$];
  bus_t        bus_log[$];
  logic [33:0] exp_q[$];
  int          n_checks = 0, n_errors = 0;
  int          cyc_cnt = 0, acc_cycle = 0, resp_cycle = 0;
  int          ack_lat = 0, stall_left = 0;
  logic        err_en = 1'b0;
  logic [31:0] err_adr = 32'd0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] slave_word(input logic [31:0] a);
    if (a == 32'h100) return 32'h80FF_FFFF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Reference load: gather bytes one by one from the word, then extend.
  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] f,
                                             input logic [31:0] a);
    int n = 1 << f[1:0];
    int off = int'(a[1:0]);
    logic [31:0] r = 32'd0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = word[8*(off+i) +: 8];
    if (!f[2] && n < 4 && r[8*n-1]) for (int i = 8*n; i < 32; i++) r[i] = 1'b1;
    return r;
  endfunction

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Slave model: decides stall/ack for the current cycle on the falling edge.
  always @(negedge clk) begin
    pend_t p;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = 32'd0;
    if (wb_cyc_o === 1'b1 && wb_stb_o === 1'b1) begin
      if (stall_left > 0) begin
        wb_stall_i = 1'b1;
        stall_left--;
      end else begin
        wb_stall_i = 1'b0;
        bus_log.push_back('{we: wb_we_o, adr: wb_adr_o, sel: wb_sel_o, dat: wb_dat_o});
        p.due = cyc_cnt + ack_lat;
        p.dat = wb_we_o ? 32'd0 : slave_word(wb_adr_o);
        p.err = err_en && (wb_adr_o == err_adr);
        pend_q.push_back(p);
      end
    end else begin
      wb_stall_i = (stall_left > 0);
    end
    if (pend_q.size() > 0 && pend_q[0].due <= cyc_cnt) begin
      p = pend_q.pop_front();
      if (p.err) wb_err_i = 1'b1;
      else       wb_ack_i = 1'b1;
      wb_dat_i = p.dat;
    end
  end

  // Response monitor: every response must match the oldest expectation.
  always @(negedge clk) begin
    logic [33:0] e;
    if (resp_valid === 1'b1) begin
      resp_cycle = cyc_cnt;
      if (exp_q.size() == 0) chk("resp_unexpected", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("resp", 64'({resp_err, resp_misaligned, resp_rdata}), 64'(e));
      end
    end
  end

  task automatic do_req(input logic st, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] wd, input logic [33:0] e, output int waited);
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_funct = f; req_addr = a; req_wdata = wd;
    #1;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 50) begin
      @(negedge clk); #1;
      waited++;
    end
    if (req_ready !== 1'b1) begin
      chk("ready_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
    end else begin
      acc_cycle = cyc_cnt;
      exp_q.push_back(e);
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    req_valid = 1'b0;
    while (exp_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [33:0] ok_load(input logic [2:0] f, input logic [31:0] a);
    return {2'b00, model_load(slave_word({a[31:2], 2'b00}), f, a)};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int   w;
    int   ws[6];
    bus_t b;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_cyc", 64'(wb_cyc_o), 64'd0);
    chk("rst_stb", 64'(wb_stb_o), 64'd0);
    chk("rst_sel", 64'(wb_sel_o), 64'd0);
    chk("rst_resp", 64'({resp_valid, resp_err, resp_misaligned, resp_rdata}), 64'd0);
    rst = 1'b1;
    #1;
    chk("post_rst_ready", 64'(req_ready), 64'd1);

    // LB / LBU at 0x103 with a zero-wait slave
    bus_log.delete();
    do_req(1'b0, 3'b000, 32'h103, 32'd0, {2'b00, 32'hFFFF_FF80}, w);
    drain();
    chk("lb_latency", 64'(resp_cycle - acc_cycle), 64'd2);
    b = (bus_log.size() > 0) ? bus_log[0] : '{we: 1'b0, adr: 32'd0, sel: 4'd0, dat: 32'd0};
    chk("lb_sel", 64'(b.sel), 64'(4'b1000));
    chk("lb_adr", 64'(b.adr), 64'h100);
    chk("lb_we", 64'(b.we), 64'd0);
    do_req(1'b0, 3'b100, 32'h103, 32'd0, {2'b00, 32'h0000_0080}, w);
    drain();

    // SH at 0x102
    bus_log.delete();
    do_req(1'b1, 3'b001, 32'h102, 32'h1234_ABCD, 34'd0, w);
    drain();
    b = (bus_log.size() > 0) ? bus_log[0] : '{we: 1'b0, adr: 32'd0, sel: 4'd0, dat: 32'd0};
    chk("sh_sel", 64'(b.sel), 64'(4'b1100));
    chk("sh_dat", 64'(b.dat), 64'hABCD_0000);
    chk("sh_we", 64'(b.we), 64'd1);
    chk("sh_adr", 64'(b.adr), 64'h100);

    // Misaligned LW, LD on a 32-bit unit, illegal store funct: no bus traffic
    bus_log.delete();
    do_req(1'b0, 3'b010, 32'h102, 32'd0, {2'b11, 32'd0}, w);
    drain();
    chk("mis_latency", 64'(resp_cycle - acc_cycle), 64'd1);
    do_req(1'b0, 3'b011, 32'h100, 32'd0, {2'b10, 32'd0}, w);
    do_req(1'b1, 3'b100, 32'h104, 32'h55, {2'b10, 32'd0}, w);
    drain();
    chk("bad_no_bus", 64'(bus_log.size()), 64'd0);

    // Six back-to-back LW: 2-cycle stall, acks 3 cycles after acceptance
    stall_left = 2;
    ack_lat = 3;
    for (int i = 0; i < 6; i++)
      do_req(1'b0, 3'b010, 32'h200 + 32'(4*i), 32'd0, ok_load(3'b010, 32'h200 + 32'(4*i)), ws[i]);
    drain();
    chk("b2b_wait_stall", 64'(ws[1]), 64'd2);
    chk("b2b_wait_r3", 64'(ws[2]), 64'd0);
    chk("b2b_wait_full", 64'(ws[4]), 64'd1);
    chk("b2b_wait_r6", 64'(ws[5]), 64'd0);

    // Bus error on the middle of three loads
    ack_lat = 1;
    err_en = 1'b1;
    err_adr = 32'h304;
    do_req(1'b0, 3'b010, 32'h300, 32'd0, ok_load(3'b010, 32'h300), w);
    do_req(1'b0, 3'b010, 32'h304, 32'd0, {2'b10, 32'd0}, w);
    do_req(1'b0, 3'b001, 32'h30A, 32'd0, ok_load(3'b001, 32'h30A), w);
    drain();
    chk("err_cyc_drop", 64'(wb_cyc_o), 64'd0);
    err_en = 1'b0;

    // Bad request behind an outstanding load waits for the bus to drain
    ack_lat = 2;
    do_req(1'b0, 3'b010, 32'h500, 32'd0, ok_load(3'b010, 32'h500), w);
    do_req(1'b0, 3'b001, 32'h501, 32'd0, {2'b11, 32'd0}, w);
    drain();
    chk("bad_order_wait", 64'(w), 64'd3);

    // Reset with two loads outstanding, stale acks arrive after release
    ack_lat = 6;
    do_req(1'b0, 3'b010, 32'h400, 32'd0, ok_load(3'b010, 32'h400), w);
    do_req(1'b0, 3'b010, 32'h404, 32'd0, ok_load(3'b010, 32'h404), w);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("mid_rst_cyc", 64'(wb_cyc_o), 64'd0);
    chk("mid_rst_stb", 64'(wb_stb_o), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    exp_q.delete();
    rst = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("stale_acks_done", 64'(pend_q.size()), 64'd0);
    chk("stale_cyc", 64'(wb_cyc_o), 64'd0);
    ack_lat = 0;
    do_req(1'b0, 3'b101, 32'h602, 32'd0, ok_load(3'b101, 32'h602), w);
    drain();

    repeat (3) @(negedge clk);
    chk("final_queue", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
